uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  - 8-bit UART receive framer: oversamples serial line rxd, detects start bit,
//    deserializes 8 data bits LSB-first, captures optional parity bit, checks stop bit.
//  - Sits directly upstream of the parity generator/checker.
//  - rx_data / rx_parity_bit / rx_check_en feed that checker's data / parity / check_en inputs.
// PARAMETERS
//  - OVERSAMPLE  16  sample_tick pulses per bit period; even, >= 4.
// PORTS
//  - clk            in   1  system clock, all logic on rising edge
//  - rst            in   1  asynchronous, active-high reset
//  - sample_tick    in   1  1-clk strobe at OVERSAMPLE x baud rate
//  - rxd            in   1  serial input, idle high
//  - parity_en      in   1  1 = frame carries a parity bit after data
//  - parity_mode    in   1  0 = even, 1 = odd; passed through to checker
//  - rx_data        out  8  last received byte, held until next frame completes
//  - rx_parity_bit  out  1  parity bit captured from line (0 if frame had none)
//  - rx_parity_mode out  1  parity_mode latched at start of the frame
//  - rx_check_en    out  1  1-clk pulse with rx_valid when latched parity_en = 1
//  - rx_valid       out  1  1-clk pulse: frame complete, outputs updated
//  - framing_error  out  1  1-clk pulse with rx_valid when stop bit sampled 0
//  - busy           out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state IDLE, tick counter 0, bit index 0, armed 0.
//    All outputs 0; rx_data 8'h00. No partial-frame output.
//  - All state/counter updates occur only on clk edges with sample_tick = 1, except the
//    1-clk output pulses.
//  - armed: set when rxd sampled 1 in IDLE. Start detection requires armed = 1, so a line
//    held low (break) never retriggers.
//  - FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
//    - IDLE: rxd sampled 0 and armed: latch parity_en/parity_mode, cnt <= 0, go START.
//    - START: at cnt = OVERSAMPLE/2-1 (bit centre), resample. rxd = 1: glitch, back to
//      IDLE, no output. rxd = 0: cnt <= 0, go DATA.
//    - DATA: sample at cnt = OVERSAMPLE-1 into shift reg bit[idx], idx 0..7. After idx 7
//      go PARITY if latched parity_en, else STOP.
//    - PARITY: sample at cnt = OVERSAMPLE-1 into parity reg, go STOP.
//    - STOP: sample at cnt = OVERSAMPLE-1.
//      - Next clk: rx_valid = 1; framing_error = ~sampled stop.
//      - rx_check_en = latched parity_en; rx_data/rx_parity_bit/rx_parity_mode updated.
//      - armed <= stop sample; go IDLE.
//  - cnt width $clog2(OVERSAMPLE); wraps to 0 after OVERSAMPLE-1 in DATA/PARITY/STOP.
//  - Latency: rx_valid 1 clk after the stop-bit centre sample (+2 clk with sync, see below).
//  - parity_en/parity_mode changes mid-frame are ignored; they take effect next frame.
//  - rx_parity_bit = 0 when latched parity_en = 0.
//  - rx_parity_mode holds its value from the last completed frame.
//  - Outputs other than pulses hold between frames. Back-to-back frames need no idle gap:
//    a start bit 1 tick after the stop centre is accepted.
// CONFIGURATION
//  - RX_SYNC_EN defined: rxd passes through a 2-flop synchronizer (reset value 1) before
//    the FSM; all sampling latencies +2 clk.
//  - RX_SYNC_EN undefined: rxd used directly, for rxd already synchronous to clk.
// TESTING
//  - OVERSAMPLE=16, parity_en=0, byte 8'hA5, stop=1
//    -> one rx_valid pulse, rx_data=8'hA5, framing_error=0, rx_check_en=0.
//  - parity_en=1, mode=0 (even), byte 8'h03, parity bit 0
//    -> rx_data=8'h03, rx_parity_bit=0, rx_check_en=1, rx_parity_mode=0.
//  - Stop bit driven 0, byte 8'h3C
//    -> rx_valid=1 with framing_error=1, rx_data=8'h3C.
//    - rxd then held low 40 bit times -> no further rx_valid.
//  - rxd low pulse of 4 ticks then high -> START glitch reject, busy returns 0,
//    no rx_valid, rx_data unchanged.
//  - Assert rst during DATA bit 4 of byte 8'hFF -> busy=0 and rx_data=8'h00 immediately.
//    - Next full frame 8'h5A received correctly.
//  - Two frames 8'h11, 8'h22 back-to-back with zero idle gap
//    -> two rx_valid pulses, values in order, no framing_error.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the serial line side and the uart_rx_frame receiver.
// master drives line/config inputs; slave is the framer producing frame results.
interface uart_rx_frame_if;
  logic       sample_tick;
  logic       rxd;
  logic       parity_en;
  logic       parity_mode;
  logic [7:0] rx_data;
  logic       rx_parity_bit;
  logic       rx_parity_mode;
  logic       rx_check_en;
  logic       rx_valid;
  logic       framing_error;
  logic       busy;

  modport master (
    output sample_tick, rxd, parity_en, parity_mode,
    input  rx_data, rx_parity_bit, rx_parity_mode, rx_check_en, rx_valid, framing_error, busy
  );

  modport slave (
    input  sample_tick, rxd, parity_en, parity_mode,
    output rx_data, rx_parity_bit, rx_parity_mode, rx_check_en, rx_valid, framing_error, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// 8-bit UART receive framer: start detect, LSB-first data, optional parity, stop check.
// Define RX_SYNC_EN to pass rxd through a 2-flop synchronizer before the FSM.
module uart_rx_frame #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic           clk,
  input logic           rst,
  uart_rx_frame_if.slave bus
);
  localparam int unsigned    CntW    = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic rxd_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], bus.rxd};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end
  assign rxd_s = sync_q[1];
`else
  assign rxd_s = bus.rxd;
`endif

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            armed_q, armed_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            pen_q, pen_d;
  logic            pmode_q, pmode_d;
  logic [7:0]      data_q, data_d;
  logic            pbit_q, pbit_d;
  logic            omode_q, omode_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            chk_q, chk_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    shift_d = shift_q;
    par_d   = par_q;
    pen_d   = pen_q;
    pmode_d = pmode_q;
    data_d  = data_q;
    pbit_d  = pbit_q;
    omode_d = omode_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    chk_d   = 1'b0;

    if (bus.sample_tick) begin
      case (state_q)
        StIdle: begin
          // Only a high-to-low transition may start a frame; a held-low break never retriggers.
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            pen_d   = bus.parity_en;
            pmode_d = bus.parity_mode;
            cnt_d   = '0;
            state_d = StStart;
          end
        end
        StStart: begin
          if (cnt_q == CntMid) begin
            if (rxd_s) begin
              state_d = StIdle;
            end else begin
              cnt_d   = '0;
              idx_d   = 3'd0;
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            shift_d[idx_q] = rxd_s;
            cnt_d          = '0;
            idx_d          = idx_q + 1'b1;
            if (idx_q == 3'd7) state_d = pen_q ? StParity : StStop;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (cnt_q == CntLast) begin
            par_d   = rxd_s;
            cnt_d   = '0;
            state_d = StStop;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            valid_d = 1'b1;
            ferr_d  = ~rxd_s;
            chk_d   = pen_q;
            data_d  = shift_q;
            pbit_d  = pen_q & par_q;
            omode_d = pmode_q;
            armed_d = rxd_s;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      armed_q <= 1'b0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      pmode_q <= 1'b0;
      data_q  <= 8'h00;
      pbit_q  <= 1'b0;
      omode_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      pmode_q <= pmode_d;
      data_q  <= data_d;
      pbit_q  <= pbit_d;
      omode_q <= omode_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      chk_q   <= chk_d;
    end
  end

  assign bus.rx_data        = data_q;
  assign bus.rx_parity_bit  = pbit_q;
  assign bus.rx_parity_mode = omode_q;
  assign bus.rx_check_en    = chk_q;
  assign bus.rx_valid       = valid_q;
  assign bus.framing_error  = ferr_q;
  assign bus.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized bench for uart_rx_frame: frames are built bit by bit on rxd and the
// expected results come from a frame-level model of what each frame should report.
module tb_uart_rx_frame;
  localparam int unsigned OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       pbit;
    logic       pmode;
    logic       chk;
    logic       ferr;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  uart_rx_frame_if bus ();

  uart_rx_frame #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One sample tick every third clock so gating on sample_tick matters.
  initial begin
    bus.sample_tick = 1'b0;
    forever begin
      repeat (2) @(negedge clk) bus.sample_tick = 1'b0;
      @(negedge clk) bus.sample_tick = 1'b1;
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   stray    = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    res_t o;
    if (bus.rx_valid === 1'b1) begin
      o.data  = bus.rx_data;
      o.pbit  = bus.rx_parity_bit;
      o.pmode = bus.rx_parity_mode;
      o.chk   = bus.rx_check_en;
      o.ferr  = bus.framing_error;
      obs_q.push_back(o);
    end else if (bus.framing_error === 1'b1 || bus.rx_check_en === 1'b1) begin
      stray++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (bus.sample_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rxd = b;
    wait_ticks(OS);
  endtask

  // Model: a frame reports its data, parity bit only if parity was enabled at the start,
  // the mode latched at the start, and a framing error exactly when stop was low.
  task automatic send_frame(input logic [7:0] data, input logic pen, input logic pbit,
                            input logic stop, input logic mode);
    res_t e;
    bus.parity_en   = pen;
    bus.parity_mode = mode;
    send_bit(1'b0);
    bus.parity_en   = 1'($urandom_range(0, 1));
    bus.parity_mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    e.data  = data;
    e.pbit  = pen ? pbit : 1'b0;
    e.pmode = mode;
    e.chk   = pen;
    e.ferr  = ~stop;
    exp_q.push_back(e);
    last_data = data;
  endtask

  task automatic check_frames();
    res_t e;
    res_t o;
    check_eq("valid_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq("rx_data", o.data, e.data);
      check_eq("rx_parity_bit", o.pbit, e.pbit);
      check_eq("rx_parity_mode", o.pmode, e.pmode);
      check_eq("rx_check_en", o.chk, e.chk);
      check_eq("framing_error", o.ferr, e.ferr);
    end
    exp_q.delete();
    obs_q.delete();
    check_eq("rx_data_hold", bus.rx_data, last_data);
  endtask

  initial begin
    rst             = 1'b1;
    bus.rxd         = 1'b1;
    bus.parity_en   = 1'b0;
    bus.parity_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_data", bus.rx_data, 8'h00);
    check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_framing_error", bus.framing_error, 1'b0);
    check_eq("rst_rx_check_en", bus.rx_check_en, 1'b0);
    check_eq("rst_rx_parity_bit", bus.rx_parity_bit, 1'b0);
    check_eq("rst_rx_parity_mode", bus.rx_parity_mode, 1'b0);
    rst = 1'b0;
    wait_ticks(4);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frames();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    check_frames();
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    check_frames();

    // Bad stop bit, then a long break: only the one errored frame may be reported.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frames();
    bus.rxd = 1'b0;
    wait_ticks(40 * OS);
    check_frames();
    check_eq("break_busy", bus.busy, 1'b0);
    bus.rxd = 1'b1;
    wait_ticks(OS);

    // Short low glitch is rejected at the start-bit centre.
    bus.rxd = 1'b0;
    wait_ticks(4);
    check_eq("glitch_busy_start", bus.busy, 1'b1);
    bus.rxd = 1'b1;
    wait_ticks(12);
    check_eq("glitch_busy_end", bus.busy, 1'b0);
    check_frames();

    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    check_frames();

    for (int k = 0; k < 12; k++) begin
      int gap;
      gap = $urandom_range(0, 20);
      if (gap > 0) begin
        bus.rxd = 1'b1;
        wait_ticks(gap);
      end
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 1'($urandom_range(0, 1)));
      check_frames();
    end

    // Reset in the middle of data bit 4 of 8'hFF.
    bus.parity_en = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_ticks(OS / 2);
    check_eq("mid_frame_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_busy", bus.busy, 1'b0);
    check_eq("async_rst_rx_data", bus.rx_data, 8'h00);
    check_eq("async_rst_rx_valid", bus.rx_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_data = 8'h00;
    check_frames();
    bus.rxd = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frames();

    check_eq("stray_pulse", stray, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
